data_mem_responder: RTL
=======================

# data_mem_responder

Word-addressed data-memory responder that serves load/store requests from the datapath across a request/ready handshake with a configurable number of wait states. It is the slave end of the processor's data-memory port and lets the datapath and control unit be exercised against a memory that does not answer combinationally. It also flags misaligned or out-of-range addresses instead of silently aliasing them.

## Interface

- DEPTH_LOG2, 6: memory holds 2^DEPTH_LOG2 32-bit words (default 64 words, byte addresses 0x000–0x0FC).
- WAIT_CYCLES, 2: wait states inserted between acceptance and response; legal range 0–15.
- CLK  input  1  clock; all state changes on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- Req  input  1  request valid; initiator holds it until it samples Ready=1.
- WE  input  1  1 = store, 0 = load; sampled with Req.
- Addr  input  32  byte address; sampled with Req.
- WD  input  32  store data; sampled with Req.
- RD  output  32  load data; valid only while Ready=1 for a load.
- Ready  output  1  one-cycle response strobe.
- AddrErr  output  1  qualifies Ready: request was rejected.

## Operation

- FSM states: IDLE, WAIT, RESP.
- IDLE: Ready=0. If Req=1 at a rising edge, latch WE, Addr, WD into internal registers. Go to WAIT with counter = WAIT_CYCLES−1, or straight to RESP if WAIT_CYCLES=0.
- WAIT: decrement the counter each edge. Leave for RESP at the edge where the counter is 0. Req, Addr, WE and WD are ignored.
- Access commit happens at the edge entering RESP.
  - Valid store: mem[Addr[DEPTH_LOG2+1:2]] ← WD.
  - Valid load: RD ← mem[Addr[DEPTH_LOG2+1:2]].
- RESP: Ready=1 for exactly one cycle, then IDLE unconditionally. Req is not sampled in RESP.
- Error check on the latched address: Addr[1:0]≠0, or any of Addr[31:DEPTH_LOG2+2]≠0.
  - On error: no memory write, RD ← 0, AddrErr ← 1 for the RESP cycle.
  - Otherwise AddrErr ← 0.
- A store response drives RD ← 0.
- Outside RESP, RD and AddrErr hold the value from the last response (0 after reset).
- Memory is a plain register array with no reset. Contents survive RESET and are undefined at power-up.

## Timing

- Reset values: state=IDLE, Ready=0, RD=0x00000000, AddrErr=0, counter=0.
- Latency: Req first seen high at edge E0 means Ready is high during the cycle after edge E0+WAIT_CYCLES. That is WAIT_CYCLES+1 cycles from acceptance.
- Throughput: one request per WAIT_CYCLES+2 cycles.
- A Req held high through RESP is accepted again in the following IDLE cycle.
- The initiator must drop Req, or present the next request, in the cycle after Ready.
- RESET has priority over everything and takes effect at the next edge.
  - RESET asserted in WAIT: the store is dropped (never committed) and the FSM goes to IDLE.
  - RESET asserted at the commit edge: reset wins and there is no write.
- Request fields change mid-transaction: the latched values are used, so there is no effect.
- Counter width is 4 bits. WAIT_CYCLES=0 must not underflow it.

## Test plan

- Reset/idle: hold RESET 2 cycles with Req=1 → Ready=0, RD=0, AddrErr=0 throughout. The first acceptance happens at the first edge after RESET falls.
- Store then load, WAIT_CYCLES=2:
  - Store 0xDEADBEEF to 0x010 → Ready exactly 3 cycles after acceptance, AddrErr=0, RD=0.
  - Load 0x010 → RD=0xDEADBEEF with Ready.
- Zero wait, WAIT_CYCLES=0:
  - Store 0x12345678 to 0x0FC → Ready in the cycle after acceptance.
  - Load 0x0FC → 0x12345678.
  - Req held high continuously → Ready every 2nd cycle.
- Address errors:
  - Store to 0x012 (misaligned) → AddrErr=1 with Ready, and a later load of 0x010 still returns 0xDEADBEEF.
  - Load 0x100 (out of range, DEPTH_LOG2=6) → AddrErr=1, RD=0.
- Reset mid-store:
  - Store 0xCAFEF00D to 0x020, assert RESET during WAIT → no Ready.
  - After reset, load 0x020 → the previous contents, not 0xCAFEF00D.
- Input changes during WAIT: accept a load of 0x010, then change Addr to 0x020 and WE to 1 in WAIT → response is the load of 0x010 and memory at 0x020 is unchanged.

Source files
------------

// File: rtl/data_mem_if.sv
// Data-memory port between the datapath (master) and a memory responder (slave).
// Request fields travel with req; rd/addr_err are qualified by the one-cycle ready strobe.
interface data_mem_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        ready;
  logic        addr_err;

  modport master (
    output req, we, addr, wd,
    input  rd, ready, addr_err
  );

  modport slave (
    input  req, we, addr, wd,
    output rd, ready, addr_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory answering load/store requests after WAIT_CYCLES wait states,
// flagging misaligned or out-of-range addresses instead of aliasing them.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | ready low; accept and latch a request when req is high
// ST_WAIT | counting down wait states; bus inputs ignored
// ST_RESP | ready high for one cycle with rd/addr_err, then back to idle
module data_mem_responder #(
  parameter int DEPTH_LOG2  = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic      clk,
  input  logic      reset,
  data_mem_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  logic [31:0] mem [DEPTH];

  state_t      state;
  logic [3:0]  cnt;
  logic        l_we;
  logic [31:0] l_addr;
  logic [31:0] l_wd;
  logic        ready_r;
  logic        addr_err_r;
  logic [31:0] rd_r;

  logic                  direct;
  logic                  commit;
  logic                  c_we;
  logic                  c_err;
  logic [31:0]           c_addr;
  logic [31:0]           c_wd;
  logic [DEPTH_LOG2-1:0] c_idx;

  // With no wait states the access commits on the accepting edge, so it must
  // use the live bus fields rather than the (not yet loaded) latches.
  always_comb begin
    direct = (WAIT_CYCLES == 0) && (state == ST_IDLE);
    c_we   = direct ? bus.we   : l_we;
    c_addr = direct ? bus.addr : l_addr;
    c_wd   = direct ? bus.wd   : l_wd;
    commit = (direct && bus.req) || ((state == ST_WAIT) && (cnt == 4'd0));
    c_err  = (|c_addr[1:0]) || (|c_addr[31:DEPTH_LOG2+2]);
    c_idx  = c_addr[DEPTH_LOG2+1:2];
  end

  // Storage is deliberately not reset; reset only suppresses the write.
  always_ff @(posedge clk) begin
    if (!reset && commit && c_we && !c_err)
      mem[c_idx] <= c_wd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      ready_r    <= 1'b0;
      addr_err_r <= 1'b0;
      rd_r       <= 32'd0;
    end else begin
      ready_r <= 1'b0;
      if (commit) begin
        ready_r    <= 1'b1;
        addr_err_r <= c_err;
        rd_r       <= (c_err || c_we) ? 32'd0 : mem[c_idx];
      end
      case (state)
        ST_IDLE: begin
          if (bus.req) begin
            l_we   <= bus.we;
            l_addr <= bus.addr;
            l_wd   <= bus.wd;
            if (WAIT_CYCLES == 0) begin
              state <= ST_RESP;
            end else begin
              cnt   <= CNT_INIT;
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) state <= ST_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready    = ready_r;
  assign bus.addr_err = addr_err_r;
  assign bus.rd       = rd_r;

endmodule
